pixel_packer: RTL and testbench

- Upstream stage of the capture FIFO.
- Takes 8-bit sensor pixels qualified by vsync/href/pixel_valid and packs PACK_RATIO pixels into one DATA_WIDTH word.
- Presents each word on out_data with a one-cycle push_strobe that drives the FIFO push_clock.
- Tracks frame/line position and flags overflow and line-length errors.

---
 rtl/pixel_packer_pkg.sv | 21 ++
 rtl/sync_edge_detect.sv | 23 ++
 rtl/pixel_packer.sv | 196 +++++++++++++++++++
 tb/tb_pixel_packer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_packer_pkg.sv
// Shared state encoding and default widths for the pixel capture path.
// No logic; imported by the packer and by the capture FIFO wrapper.
// Backpressure: n/a.
package pixel_packer_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FRAME = 3'd1,
        WAIT_LINE  = 3'd2,
        LINE       = 3'd3,
        FLUSH      = 3'd4
    } pack_state_t;

    localparam int DEFAULT_PIXEL_WIDTH = 8;
    localparam int DEFAULT_DATA_WIDTH  = 32;

    function automatic int pack_ratio(input int data_width, input int pixel_width);
        return data_width / pixel_width;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registers a level input once and flags its rising edge.
// Latency: rise is combinational from sig against last cycle's value.
// Backpressure: none.
module sync_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/pixel_packer.sv
// Packs PACK_RATIO sensor pixels (first pixel in LSBs) into one word per FIFO push.
// Latency: word and push_strobe appear the cycle after the completing pixel.
// Backpressure: none upstream; a push while FIFO not ready/full is dropped and sets overflow.
module pixel_packer
    import pixel_packer_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int PIXEL_WIDTH     = DEFAULT_PIXEL_WIDTH,
    parameter int PIXELS_PER_LINE = 640
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   vsync,
    input  logic                   href,
    input  logic                   pixel_valid,
    input  logic [PIXEL_WIDTH-1:0] pixel_data,
    input  logic                   fifo_ready,
    input  logic                   fifo_full,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   push_strobe,
    output logic                   frame_done,
    output logic [15:0]            line_count,
    output logic                   overflow,
    output logic                   length_error
);

    localparam int PACK_RATIO = pack_ratio(DATA_WIDTH, PIXEL_WIDTH);
    localparam int LANE_W     = (PACK_RATIO > 1) ? $clog2(PACK_RATIO) : 1;
    localparam int CNT_W      = $clog2(PIXELS_PER_LINE + 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK_RATIO - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(PIXELS_PER_LINE);

    // A single-pixel word would let push_strobe stay high back to back,
    // which the FIFO's push edge detector cannot see.
    if (PACK_RATIO < 2) begin : g_bad_ratio
        $error("pixel_packer: PACK_RATIO must be at least 2");
    end
    if (DATA_WIDTH % PIXEL_WIDTH != 0) begin : g_bad_width
        $error("pixel_packer: DATA_WIDTH must be a multiple of PIXEL_WIDTH");
    end

    pack_state_t           state;
    logic [LANE_W-1:0]     lane;
    logic [CNT_W-1:0]      pix_cnt;
    logic [DATA_WIDTH-1:0] word_buf;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] push_word;
    logic                  enable_q;
    logic                  end_pend;
    logic                  done_pend;
    logic                  vsync_rise;
    logic                  take;
    logic                  room;
    logic                  line_end;
    logic                  push_req;

    sync_edge_detect u_vsync_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .sig     (vsync),
        .rise    (vsync_rise)
    );

    // Frame end wins over a pixel offered in the same cycle as the vsync edge.
    assign take     = (state == LINE) && href && pixel_valid && !vsync_rise;
    assign line_end = (state == LINE) && (!href || vsync_rise);
    assign room     = (pix_cnt != CNT_MAX);

    always_comb begin
        merged = word_buf;
        for (int k = 0; k < PACK_RATIO; k++) begin
            if (lane == LANE_W'(k)) begin
                merged[k*PIXEL_WIDTH +: PIXEL_WIDTH] = pixel_data;
            end
        end
    end

    always_comb begin
        push_req  = 1'b0;
        push_word = merged;
        if (state == FLUSH) begin
            push_req  = 1'b1;
            push_word = word_buf;
        end else if (take && room && (lane == LAST_LANE)) begin
            push_req  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            lane         <= '0;
            pix_cnt      <= '0;
            word_buf     <= '0;
            enable_q     <= 1'b0;
            end_pend     <= 1'b0;
            done_pend    <= 1'b0;
            out_data     <= '0;
            push_strobe  <= 1'b0;
            frame_done   <= 1'b0;
            line_count   <= '0;
            overflow     <= 1'b0;
            length_error <= 1'b0;
        end else begin
            enable_q    <= enable;
            push_strobe <= 1'b0;
            frame_done  <= 1'b0;
            if (!enable) begin
                state     <= IDLE;
                lane      <= '0;
                pix_cnt   <= '0;
                word_buf  <= '0;
                end_pend  <= 1'b0;
                done_pend <= 1'b0;
            end else begin
                if (!enable_q) begin
                    overflow     <= 1'b0;
                    length_error <= 1'b0;
                end
                if (push_req) begin
                    if (fifo_ready && !fifo_full) begin
                        out_data    <= push_word;
                        push_strobe <= 1'b1;
                    end else begin
                        overflow    <= 1'b1;
                    end
                end
                if (done_pend) begin
                    frame_done <= 1'b1;
                    line_count <= '0;
                    done_pend  <= 1'b0;
                end
                case (state)
                    IDLE: state <= WAIT_FRAME;
                    WAIT_FRAME: begin
                        if (vsync_rise) begin
                            state      <= WAIT_LINE;
                            line_count <= '0;
                        end
                    end
                    WAIT_LINE: begin
                        if (vsync_rise) begin
                            frame_done <= 1'b1;
                            line_count <= '0;
                        end else if (href) begin
                            state    <= LINE;
                            lane     <= '0;
                            pix_cnt  <= '0;
                            word_buf <= '0;
                        end
                    end
                    LINE: begin
                        if (line_end) begin
                            if (lane != '0) begin
                                state    <= FLUSH;
                                end_pend <= vsync_rise;
                            end else begin
                                state      <= WAIT_LINE;
                                frame_done <= vsync_rise;
                                line_count <= vsync_rise ? 16'd0 : line_count + 16'd1;
                            end
                        end else if (take) begin
                            if (!room) begin
                                length_error <= 1'b1;
                            end else begin
                                pix_cnt <= pix_cnt + CNT_W'(1);
                                if (lane == LAST_LANE) begin
                                    lane     <= '0;
                                    word_buf <= '0;
                                end else begin
                                    lane     <= lane + LANE_W'(1);
                                    word_buf <= merged;
                                end
                            end
                        end
                    end
                    FLUSH: begin
                        state    <= WAIT_LINE;
                        lane     <= '0;
                        word_buf <= '0;
                        end_pend <= 1'b0;
                        // Frame-ending flush reports frame_done one cycle after the word.
                        if (end_pend || vsync_rise) begin
                            done_pend  <= 1'b1;
                        end else begin
                            line_count <= line_count + 16'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_packer.sv
// Randomized and directed bench for pixel_packer against a line/word-level model.
module tb_pixel_packer;

    localparam int DW  = 32;
    localparam int PW  = 8;
    localparam int PPL = 8;
    localparam int PR  = DW / PW;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          enable = 1'b0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic          pixel_valid = 1'b0;
    logic [PW-1:0] pixel_data = '0;
    logic          fifo_ready = 1'b1;
    logic          fifo_full = 1'b0;
    logic [DW-1:0] out_data;
    logic          push_strobe;
    logic          frame_done;
    logic [15:0]   line_count;
    logic          overflow;
    logic          length_error;

    pixel_packer #(
        .DATA_WIDTH      (DW),
        .PIXEL_WIDTH     (PW),
        .PIXELS_PER_LINE (PPL)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .vsync        (vsync),
        .href         (href),
        .pixel_valid  (pixel_valid),
        .pixel_data   (pixel_data),
        .fifo_ready   (fifo_ready),
        .fifo_full    (fifo_full),
        .out_data     (out_data),
        .push_strobe  (push_strobe),
        .frame_done   (frame_done),
        .line_count   (line_count),
        .overflow     (overflow),
        .length_error (length_error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int n_strobes = 0;

    // Model state: expected pushes/frame_done keyed by the clock edge that produces them.
    logic [DW-1:0] exp_push[int];
    bit            exp_done[int];
    logic [DW-1:0] words_log[$];
    logic [PW-1:0] src[$];
    bit            track = 1'b0;
    bit            rnd_fifo = 1'b0;
    int            m_lc = 0;
    bit            m_ovf = 1'b0;
    bit            m_lerr = 1'b0;
    bit            m_started = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (push_strobe === 1'b1) n_strobes++;
        if (track) begin
            if (exp_push.exists(cyc)) begin
                check("push_strobe", push_strobe, 1);
                check("out_data", out_data, exp_push[cyc]);
            end else begin
                check("push_idle", push_strobe, 0);
            end
            check("frame_done", frame_done, exp_done.exists(cyc));
        end
    end

    function automatic logic [DW-1:0] pack(input logic [PW-1:0] q[$]);
        logic [DW-1:0] w = '0;
        for (int i = 0; i < q.size(); i++) w = w | (DW'(q[i]) << (i * PW));
        return w;
    endfunction

    task automatic drive(input logic h, input logic pv, input logic [PW-1:0] pd, input logic vs,
                         input bit full_now, output int e, output bit ok);
        href = h;
        pixel_valid = pv;
        pixel_data = pd;
        vsync = vs;
        if (full_now) begin
            fifo_full = 1'b1;
            fifo_ready = 1'b1;
        end else if (rnd_fifo) begin
            fifo_full = ($urandom_range(0, 9) == 0);
            fifo_ready = ($urandom_range(0, 9) != 0);
        end else begin
            fifo_full = 1'b0;
            fifo_ready = 1'b1;
        end
        ok = fifo_ready && !fifo_full;
        @(posedge clock);
        #1;
        e = cyc;
    endtask

    task automatic idle(input int n);
        int e;
        bit ok;
        repeat (n) drive(0, 0, '0, 0, 0, e, ok);
    endtask

    task automatic expect_word(input int e, input bit ok, input logic [DW-1:0] w);
        words_log.push_back(w);
        if (ok) exp_push[e] = w;
        else m_ovf = 1'b1;
    endtask

    task automatic start_frame();
        int e;
        bit ok;
        drive(0, 0, '0, 1, 0, e, ok);
        if (m_started) exp_done[e] = 1'b1;
        m_started = 1'b1;
        m_lc = 0;
        idle(1);
    endtask

    task automatic toggle_enable();
        enable = 1'b0;
        idle(2);
        enable = 1'b1;
        idle(1);
        m_ovf = 1'b0;
        m_lerr = 1'b0;
        m_started = 1'b0;
        check("overflow_cleared", overflow, m_ovf);
        check("length_error_cleared", length_error, m_lerr);
    endtask

    // Sends the pixels in src as one href line; href's first cycle carries no pixel.
    task automatic send_line(input int full_at, input int vs_after, input bit gaps);
        logic [PW-1:0] acc[$];
        logic [PW-1:0] d;
        int e;
        bit ok;
        int offered = 0;
        int accepted = 0;
        drive(1, 0, '0, 0, 0, e, ok);
        while (src.size() > 0) begin
            if (vs_after >= 0 && offered == vs_after) break;
            if (gaps && $urandom_range(0, 3) == 0) begin
                drive(1, 0, PW'($urandom), 0, 0, e, ok);
                continue;
            end
            d = src.pop_front();
            drive(1, 1, d, 0, offered == full_at, e, ok);
            offered++;
            if (accepted < PPL) begin
                accepted++;
                acc.push_back(d);
                if (acc.size() == PR) begin
                    expect_word(e, ok, pack(acc));
                    acc.delete();
                end
            end else begin
                m_lerr = 1'b1;
            end
        end
        src.delete();
        if (vs_after >= 0) begin
            drive(0, 0, '0, 1, 0, e, ok);
            if (acc.size() != 0) begin
                drive(0, 0, '0, 0, 0, e, ok);
                expect_word(e, ok, pack(acc));
                drive(0, 0, '0, 0, 0, e, ok);
            end
            exp_done[e] = 1'b1;
            m_lc = 0;
        end else begin
            drive(0, 0, '0, 0, 0, e, ok);
            if (acc.size() != 0) begin
                drive(0, 0, '0, 0, 0, e, ok);
                expect_word(e, ok, pack(acc));
            end
            m_lc = (m_lc + 1) % 65536;
        end
        idle(2);
        check("line_count", line_count, m_lc);
        check("overflow", overflow, m_ovf);
        check("length_error", length_error, m_lerr);
    endtask

    task automatic load_seq(input logic [PW-1:0] base, input logic [PW-1:0] stride, input int n);
        logic [PW-1:0] v = base;
        src.delete();
        for (int i = 0; i < n; i++) begin
            src.push_back(v);
            v = v + stride;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_push_strobe"}, push_strobe, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_line_count"}, line_count, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_length_error"}, length_error, 0);
    endtask

    task automatic scenario_basic(input string tag);
        start_frame();
        words_log.delete();
        load_seq(8'h01, 8'h01, 8);
        send_line(-1, -1, 0);
        check({tag, "_model_w0"}, words_log[0], 32'h04030201);
        check({tag, "_model_w1"}, words_log[1], 32'h08070605);
        check({tag, "_out_data_held"}, out_data, 32'h08070605);
        check({tag, "_line_count"}, line_count, 1);
    endtask

    initial begin
        int e;
        bit ok;
        int s0;
        int n;
        int va;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        track = 1'b1;
        enable = 1'b1;
        idle(1);

        scenario_basic("s1");

        start_frame();
        words_log.delete();
        load_seq(8'hA0, 8'h01, 6);
        send_line(-1, -1, 0);
        check("s2_model_full", words_log[0], 32'hA3A2A1A0);
        check("s2_model_flush", words_log[1], 32'h0000A5A4);
        check("s2_line_count", line_count, 1);

        start_frame();
        load_seq(8'h30, 8'h01, 8);
        send_line(3, -1, 0);
        check("s3_overflow_set", overflow, 1);
        load_seq(8'h40, 8'h01, 4);
        send_line(-1, -1, 0);
        check("s3_overflow_sticky", overflow, 1);
        toggle_enable();
        check("s3_overflow_after_toggle", overflow, 0);

        start_frame();
        words_log.delete();
        s0 = n_strobes;
        load_seq(8'h50, 8'h01, 12);
        send_line(-1, -1, 0);
        check("s4_strobes", n_strobes - s0, 2);
        check("s4_model_words", words_log.size(), 2);
        check("s4_length_error", length_error, 1);
        toggle_enable();

        start_frame();
        words_log.delete();
        load_seq(8'h11, 8'h11, 3);
        send_line(-1, 3, 0);
        check("s5_model_flush", words_log[0], 32'h00332211);
        check("s5_line_count", line_count, 0);

        start_frame();
        drive(1, 0, '0, 0, 0, e, ok);
        drive(1, 1, 8'h01, 0, 0, e, ok);
        drive(1, 1, 8'h02, 0, 0, e, ok);
        #2;
        href = 1'b0;
        pixel_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("s6_async");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        m_lc = 0;
        m_ovf = 1'b0;
        m_lerr = 1'b0;
        m_started = 1'b0;
        idle(1);
        scenario_basic("s6");

        rnd_fifo = 1'b1;
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0: begin toggle_enable(); start_frame(); end
                1: start_frame();
                default: ;
            endcase
            n = $urandom_range(0, 12);
            src.delete();
            for (int i = 0; i < n; i++) src.push_back(PW'($urandom));
            va = (n > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
            send_line(-1, va, 1);
        end
        rnd_fifo = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
